// File: rtl/pu_io_arbiter.sv
// pu_io_arbiter: round-robin arbiter sharing one single-port PU data memory among
// NUM_REQ requesters, sequencing loads, stores, RISC-V AMOs and LR/SC.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req_*                 per-requester io request (valid, wr, atomic, funct5,
//                           addr, wdata, tid, fid), packed NUM_REQ-wide
//   o_req_ready             one-hot combinational grant in IDLE
//   o_resp_valid            one-hot completion pulse in RESP
//   o_resp_rdata/tid/fid    load/AMO old value or SC status, echoed ids
//   o_mem_en/wr/addr/wdata  single-port memory request
//   i_mem_rdata             memory read data, one cycle after a read
module pu_io_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_NBITS = 12,
  parameter int TID_NBITS  = 8,
  parameter int FID_NBITS  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0]              i_req_wr,
  input  logic [NUM_REQ-1:0]              i_req_atomic,
  input  logic [5*NUM_REQ-1:0]            i_req_funct5,
  input  logic [ADDR_NBITS*NUM_REQ-1:0]   i_req_addr,
  input  logic [32*NUM_REQ-1:0]           i_req_wdata,
  input  logic [TID_NBITS*NUM_REQ-1:0]    i_req_tid,
  input  logic [FID_NBITS*NUM_REQ-1:0]    i_req_fid,
  output logic [NUM_REQ-1:0]              o_resp_valid,
  output logic [31:0]                     o_resp_rdata,
  output logic [TID_NBITS-1:0]            o_resp_tid,
  output logic [FID_NBITS-1:0]            o_resp_fid,
  output logic                            o_mem_en,
  output logic                            o_mem_wr,
  output logic [ADDR_NBITS-1:0]           o_mem_addr,
  output logic [31:0]                     o_mem_wdata,
  input  logic [31:0]                     i_mem_rdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t                r_state;
  logic [IW-1:0]         r_rr_ptr, r_gidx, w_gidx, w_idx;
  logic                  r_wr, r_atomic;
  logic [4:0]            r_funct5;
  logic [ADDR_NBITS-1:0] r_addr;
  logic [31:0]           r_wdata, w_amo;
  logic [TID_NBITS-1:0]  r_tid;
  logic [FID_NBITS-1:0]  r_fid;
  logic [NUM_REQ-1:0]    r_res_v;
  logic [ADDR_NBITS-1:0] r_res_addr [NUM_REQ];
  logic w_found, w_iss, w_rsp, w_is_st, w_is_lr, w_is_sc, w_is_amo, w_sc_ok, w_lt_s, w_lt_u;
  // Descending scan so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_gidx = '0;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (i_req_valid[w_idx]) w_gidx = w_idx;
    end
  end
  assign w_found  = |i_req_valid;
  assign w_iss    = r_state == ISSUE;
  assign w_rsp    = r_state == RESP;
  assign w_is_st  = !r_atomic && r_wr;
  assign w_is_lr  = r_atomic && r_funct5 == 5'b00010;
  assign w_is_sc  = r_atomic && r_funct5 == 5'b00011;
  assign w_is_amo = r_atomic && (r_funct5 inside {5'b00000, 5'b00001, 5'b00100, 5'b01000,
                                                  5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100});
  // Own reservation is only touched in RESP, so this stays stable across ISSUE and RESP.
  assign w_sc_ok  = w_is_sc && r_res_v[r_gidx] && r_res_addr[r_gidx] == r_addr;
  assign w_lt_s   = $signed(i_mem_rdata) < $signed(r_wdata);
  assign w_lt_u   = i_mem_rdata < r_wdata;
  assign w_amo = r_funct5 == 5'b00000 ? i_mem_rdata + r_wdata :
                 r_funct5 == 5'b00001 ? r_wdata :
                 r_funct5 == 5'b00100 ? i_mem_rdata ^ r_wdata :
                 r_funct5 == 5'b01000 ? i_mem_rdata | r_wdata :
                 r_funct5 == 5'b01100 ? i_mem_rdata & r_wdata :
                 r_funct5 == 5'b10000 ? (w_lt_s ? i_mem_rdata : r_wdata) :
                 r_funct5 == 5'b10100 ? (w_lt_s ? r_wdata : i_mem_rdata) :
                 r_funct5 == 5'b11000 ? (w_lt_u ? i_mem_rdata : r_wdata) :
                                        (w_lt_u ? r_wdata : i_mem_rdata);
  // Ready is masked by rst_n so outputs read zero while reset is held.
  assign o_req_ready  = (rst_n && r_state == IDLE && w_found) ? NUM_REQ'(1) << w_gidx : '0;
  assign o_mem_en     = w_iss || (w_rsp && w_is_amo);
  assign o_mem_wr     = (w_iss && (w_is_st || w_sc_ok)) || (w_rsp && w_is_amo);
  assign o_mem_addr   = o_mem_en ? r_addr : '0;
  assign o_mem_wdata  = (w_iss && o_mem_wr) ? r_wdata : (w_rsp && w_is_amo) ? w_amo : '0;
  assign o_resp_valid = w_rsp ? NUM_REQ'(1) << r_gidx : '0;
  assign o_resp_rdata = (!w_rsp || w_is_st) ? '0 : w_is_sc ? {31'b0, !w_sc_ok} : i_mem_rdata;
  assign o_resp_tid   = w_rsp ? r_tid : '0;
  assign o_resp_fid   = w_rsp ? r_fid : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_wr     <= 1'b0;
      r_atomic <= 1'b0;
      r_funct5 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_tid    <= '0;
      r_fid    <= '0;
      r_res_v  <= '0;
      for (int j = 0; j < NUM_REQ; j++) r_res_addr[j] <= '0;
    end else begin
      r_state <= r_state == IDLE ? (w_found ? ISSUE : IDLE) : r_state == ISSUE ? RESP : IDLE;
      if (r_state == IDLE && w_found) begin
        r_rr_ptr <= (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
        r_gidx   <= w_gidx;
        r_wr     <= i_req_wr[w_gidx];
        r_atomic <= i_req_atomic[w_gidx];
        r_funct5 <= i_req_funct5[w_gidx*5 +: 5];
        r_addr   <= i_req_addr[w_gidx*ADDR_NBITS +: ADDR_NBITS];
        r_wdata  <= i_req_wdata[w_gidx*32 +: 32];
        r_tid    <= i_req_tid[w_gidx*TID_NBITS +: TID_NBITS];
        r_fid    <= i_req_fid[w_gidx*FID_NBITS +: FID_NBITS];
      end
      // A write to A kills every other requester's reservation on A.
      for (int j = 0; j < NUM_REQ; j++)
        if (o_mem_wr && IW'(j) != r_gidx && r_res_addr[j] == r_addr) r_res_v[j] <= 1'b0;
      if (w_rsp && (w_is_lr || w_is_sc)) begin
        r_res_v[r_gidx]    <= w_is_lr;
        r_res_addr[r_gidx] <= r_addr;
      end
    end
  end
endmodule

// File: tb/tb_pu_io_arbiter.sv
// tb_pu_io_arbiter: directed self-checking bench for pu_io_arbiter with a simple memory.
module tb_pu_io_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid, ready, wr, atomic, resp_valid;
  logic [19:0] funct5;
  logic [47:0] addr;
  logic [127:0] wdata;
  logic [31:0] tid, fid;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [7:0]  resp_tid, resp_fid;
  logic        mem_en, mem_wr;
  logic [11:0] mem_addr;
  logic [31:0] mem [0:4095];
  int n_asrt = 0, n_fail = 0;
  logic [3:0]  g_rdy, rsp_valid;
  logic        iss_en, iss_wr, rsp_en, rsp_wr;
  logic [11:0] iss_addr, rsp_addr;
  logic [31:0] iss_wdata, rsp_wdata, rsp_rdata;
  logic [7:0]  rsp_tid, rsp_fid;
  logic [3:0]  exp_rr [0:8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};

  pu_io_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(valid), .o_req_ready(ready), .i_req_wr(wr), .i_req_atomic(atomic),
    .i_req_funct5(funct5), .i_req_addr(addr), .i_req_wdata(wdata),
    .i_req_tid(tid), .i_req_fid(fid),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_tid(resp_tid), .o_resp_fid(resp_fid),
    .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic w, input logic a, input logic [4:0] f,
                       input logic [11:0] ad, input logic [31:0] d, input logic [7:0] t, input logic [7:0] fi);
    wr[k] = w;
    atomic[k] = a;
    funct5[k*5 +: 5] = f;
    addr[k*12 +: 12] = ad;
    wdata[k*32 +: 32] = d;
    tid[k*8 +: 8] = t;
    fid[k*8 +: 8] = fi;
    valid[k] = 1'b1;
  endtask

  // Starts and ends at posedge+1 with the DUT in IDLE; records the three cycles.
  task automatic txn(input int k, input logic w, input logic a, input logic [4:0] f,
                     input logic [11:0] ad, input logic [31:0] d, input logic [7:0] t, input logic [7:0] fi);
    drive(k, w, a, f, ad, d, t, fi);
    @(negedge clk);
    g_rdy = ready;
    @(posedge clk) #1;
    valid[k] = 1'b0;
    @(negedge clk);
    iss_en = mem_en; iss_wr = mem_wr; iss_addr = mem_addr; iss_wdata = mem_wdata;
    @(negedge clk);
    rsp_valid = resp_valid; rsp_rdata = resp_rdata; rsp_tid = resp_tid; rsp_fid = resp_fid;
    rsp_en = mem_en; rsp_wr = mem_wr; rsp_addr = mem_addr; rsp_wdata = mem_wdata;
    @(posedge clk) #1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0; wr = '0; atomic = '0; funct5 = '0; addr = '0; wdata = '0; tid = '0; fid = '0;
    repeat (2) @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 5'd0, 12'h010, 32'h0, 8'h11, 8'h22);
    @(negedge clk);
    chk("rst_ready", ready, 4'h0);
    chk("rst_resp_valid", resp_valid, 4'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_tid_fid", {resp_tid, resp_fid}, 16'h0);
    chk("rst_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 46'h0);
    valid = '0;
    @(posedge clk) #1 rst_n = 1'b1;
    // preload then single load
    txn(0, 1'b1, 1'b0, 5'd0, 12'h010, 32'hDEADBEEF, 8'h01, 8'h02);
    chk("st_iss", {iss_en, iss_wr, iss_addr, iss_wdata}, {1'b1, 1'b1, 12'h010, 32'hDEADBEEF});
    chk("st_rdata", rsp_rdata, 32'h0);
    txn(0, 1'b0, 1'b0, 5'd0, 12'h010, 32'h0, 8'h11, 8'h22);
    chk("ld_ready", g_rdy, 4'h1);
    chk("ld_iss", {iss_en, iss_wr, iss_addr}, {1'b1, 1'b0, 12'h010});
    chk("ld_resp_valid", rsp_valid, 4'h1);
    chk("ld_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("ld_tid_fid", {rsp_tid, rsp_fid}, 16'h1122);
    chk("ld_resp_mem_idle", {rsp_en, rsp_wr}, 2'b00);
    // round robin from reset
    rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 5'd0, 12'h010, 32'h0, 8'(k), 8'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), ready, exp_rr[i]);
      @(posedge clk) #1;
      if (i == 4) valid[1] = 1'b0;
      if (i == 8) valid = '0;
      @(posedge clk);
      @(posedge clk) #1;
    end
    // wrap: rr_ptr is now 3
    drive(0, 1'b0, 1'b0, 5'd0, 12'h010, 32'h0, 8'h0, 8'h0);
    drive(3, 1'b0, 1'b0, 5'd0, 12'h010, 32'h0, 8'h3, 8'h0);
    @(negedge clk);
    chk("wrap_grant3", ready, 4'h8);
    @(posedge clk) #1 valid[3] = 1'b0;
    @(negedge clk);
    chk("wrap_busy_ready", ready, 4'h0);
    @(negedge clk);
    chk("wrap_resp3", resp_valid, 4'h8);
    @(posedge clk) #1;
    @(negedge clk);
    chk("wrap_grant0", ready, 4'h1);
    @(posedge clk) #1 valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk) #1;
    // AMOs
    txn(3, 1'b1, 1'b0, 5'd0, 12'h020, 32'h7FFFFFFF, 8'h0, 8'h0);
    txn(3, 1'b1, 1'b0, 5'd0, 12'h024, 32'hFFFFFFFF, 8'h0, 8'h0);
    txn(3, 1'b1, 1'b0, 5'd0, 12'h028, 32'hFFFFFFFF, 8'h0, 8'h0);
    txn(2, 1'b0, 1'b1, 5'b00000, 12'h020, 32'h1, 8'h5A, 8'hA5);
    chk("add_iss_read", {iss_en, iss_wr, iss_addr}, {1'b1, 1'b0, 12'h020});
    chk("add_resp_valid", rsp_valid, 4'h4);
    chk("add_rdata", rsp_rdata, 32'h7FFFFFFF);
    chk("add_write", {rsp_en, rsp_wr, rsp_addr, rsp_wdata}, {1'b1, 1'b1, 12'h020, 32'h80000000});
    chk("add_mem", mem[12'h020], 32'h80000000);
    txn(2, 1'b0, 1'b1, 5'b10000, 12'h024, 32'h5, 8'h0, 8'h0);
    chk("min_rdata", rsp_rdata, 32'hFFFFFFFF);
    chk("min_write", {rsp_wr, rsp_wdata}, {1'b1, 32'hFFFFFFFF});
    txn(2, 1'b0, 1'b1, 5'b11000, 12'h028, 32'h5, 8'h0, 8'h0);
    chk("minu_write", {rsp_wr, rsp_wdata}, {1'b1, 32'h5});
    chk("minu_mem", mem[12'h028], 32'h5);
    txn(2, 1'b0, 1'b1, 5'b00111, 12'h028, 32'h9, 8'h0, 8'h0);
    chk("badf5_nowrite", {rsp_en, rsp_wr}, 2'b00);
    chk("badf5_rdata", rsp_rdata, 32'h5);
    // LR/SC
    txn(1, 1'b1, 1'b0, 5'd0, 12'h040, 32'h1234, 8'h0, 8'h0);
    txn(0, 1'b0, 1'b1, 5'b00010, 12'h040, 32'h0, 8'h0, 8'h0);
    chk("lr_rdata", rsp_rdata, 32'h1234);
    txn(0, 1'b0, 1'b1, 5'b00011, 12'h040, 32'h9, 8'h0, 8'h0);
    chk("sc_ok_write", {iss_wr, iss_addr, iss_wdata}, {1'b1, 12'h040, 32'h9});
    chk("sc_ok_rdata", rsp_rdata, 32'h0);
    chk("sc_ok_mem", mem[12'h040], 32'h9);
    txn(0, 1'b0, 1'b1, 5'b00010, 12'h040, 32'h0, 8'h0, 8'h0);
    txn(1, 1'b1, 1'b0, 5'd0, 12'h040, 32'h7, 8'h0, 8'h0);
    txn(0, 1'b0, 1'b1, 5'b00011, 12'h040, 32'h9, 8'h0, 8'h0);
    chk("sc_lost_nowrite", iss_wr, 1'b0);
    chk("sc_lost_rdata", rsp_rdata, 32'h1);
    chk("sc_lost_mem", mem[12'h040], 32'h7);
    txn(3, 1'b0, 1'b1, 5'b00011, 12'h050, 32'h9, 8'h0, 8'h0);
    chk("sc_nolr", {iss_wr, rsp_rdata}, {1'b0, 32'h1});
    // reset during ISSUE of an AMO
    txn(2, 1'b1, 1'b0, 5'd0, 12'h060, 32'h10, 8'h0, 8'h0);
    txn(0, 1'b0, 1'b1, 5'b00010, 12'h070, 32'h0, 8'h0, 8'h0);
    drive(1, 1'b0, 1'b1, 5'b00000, 12'h060, 32'h1, 8'h0, 8'h0);
    @(negedge clk);
    chk("mid_ready", ready, 4'h2);
    @(posedge clk) #1 valid[1] = 1'b0;
    @(negedge clk);
    chk("mid_issue_en", mem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_drop", {mem_en, mem_wr, resp_valid}, 6'h0);
    @(negedge clk);
    chk("mid_rst_hold", {mem_en, mem_wr, resp_valid}, 6'h0);
    @(posedge clk) #1 rst_n = 1'b1;
    chk("mid_rst_mem", mem[12'h060], 32'h10);
    txn(0, 1'b0, 1'b1, 5'b00011, 12'h070, 32'h3, 8'h0, 8'h0);
    chk("mid_sc_fail", {iss_wr, rsp_rdata}, {1'b0, 32'h1});
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
